multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS-subset datapath. It decodes the 6-bit opcode and, one step per cycle, generates the register/memory/PC enables, the mux selects and the 2-bit alu_op. The 2-bit alu_op feeds the existing ALU control decoder. The block also handles the memory handshake by stalling FETCH, MEM_READ and MEM_WRITE until mem_ready.

Parameters:
ENABLE_ADDI, 1, when 1 opcode 001000 (addi) is legal and gets its two states; when 0, addi is treated as illegal.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  instruction[31:26] from the instruction register
zero  input  1  ALU zero flag, used in BRANCH
mem_ready  input  1  memory completes the current access this cycle
pc_en  output  1  PC load enable = pc_write | (pc_write_cond & zero)
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  write-back select: 1 = MDR, 0 = ALUOut
reg_dst  output  1  destination register: 1 = rd, 0 = rt
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
alu_src_b  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
alu_op  output  2  00 = add, 01 = sub, 10 = decode funct
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal  output  1  one-cycle pulse when an unknown opcode is decoded
state  output  4  current state encoding, for debug and the bench

Behaviour:
- Reset: synchronous, active-high. While reset=1 at a rising edge, state <= FETCH.
  - While reset is high, every control output is forced to 0 regardless of state; state reads 0.
  - Reset asserted mid-instruction abandons that instruction; no further writes occur.
- All outputs are Moore functions of state. Exceptions: ir_write and pc_en in FETCH are gated by mem_ready; pc_en in BRANCH is gated by zero.
- State encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - EXECUTE = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EXEC = 10, ADDI_WB = 11
  - Encodings 12-15 are unreachable; if entered, the FSM goes to FETCH next cycle with outputs 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write = pc_en = mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (computes the branch target). Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC (only when ENABLE_ADDI=1)
  - any other opcode -> FETCH, with illegal=1 for this cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next: R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero. Next: FETCH.
- JUMP: pc_source=10, pc_en=1. Next: FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- Any output not listed for a state is 0.
- Sampling rules:
  - opcode is sampled only in DECODE and MEM_ADDR; changes at other times are ignored.
  - mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Latency with mem_ready held at 1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4. Each cycle of mem_ready=0 in a waiting state adds one cycle.

Decomposition:
- Shared header control_defs.vh holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - the 12 state encodings
  - alu_op codes ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - alu_src_b and pc_source select codes
- One sub-module is natural: multicycle_control_decode, the purely combinational state-to-outputs decoder. The top level keeps the state register, next-state logic and reset gating.

Test Plan:
- reset=1 for 2 cycles, then released with opcode=000000 and mem_ready=1 -> during reset all outputs are 0. State sequence 0,1,6,7,0; alu_op=10 in state 6; reg_write=1 and reg_dst=1 in state 7.
- lw (100011), mem_ready held 0 for 3 cycles in MEM_READ -> sequence 0,1,2,3,3,3,3,4,0. mem_read=1 and i_or_d=1 throughout state 3; reg_write=1 and mem_to_reg=1 in state 4.
- beq (000100) with zero=1, then again with zero=0 -> state 8 has alu_op=01 and pc_source=01. pc_en=1 in the first case, 0 in the second.
- j (000010), then opcode 111111 -> for j: state 9 with pc_source=10 and pc_en=1. For 111111: illegal=1 for exactly one cycle in DECODE, then state returns to 0.
- FETCH with mem_ready=0 for 2 cycles, then 1 -> ir_write and pc_en stay 0 while waiting, go to 1 in the mem_ready cycle; next state is 1.
- reset asserted while in MEM_WRITE with mem_ready=0 -> state=0 on the next edge, mem_write drops to 0 in the reset cycle, no reg_write is observed.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Opcodes, FSM states and select codes for the multicycle control.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_EXECUTE   = 4'd6,
      ST_R_WB      = 4'd7,
      ST_BRANCH    = 4'd8,
      ST_JUMP      = 4'd9,
      ST_ADDI_EXEC = 4'd10,
      ST_ADDI_WB   = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_en;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   // Successor of DECODE; ST_FETCH means the opcode is not supported.
   function automatic state_t decode_opcode(logic [5:0] op, bit addi_en);
      state_t nxt;
      case (op)
         OP_RTYPE:     nxt = ST_EXECUTE;
         OP_LW, OP_SW: nxt = ST_MEM_ADDR;
         OP_BEQ:       nxt = ST_BRANCH;
         OP_J:         nxt = ST_JUMP;
         OP_ADDI:      nxt = addi_en ? ST_ADDI_EXEC : ST_FETCH;
         default:      nxt = ST_FETCH;
      endcase
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Datapath-facing bundle: decode inputs and control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
   import multicycle_control_pkg::*;

   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
             reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
             reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, state
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_decode.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_decode
// Description : Combinational state-to-control decoder for the multicycle FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_decode
   import multicycle_control_pkg::*;
(
   input  state_t i_state,
   input  logic   i_zero,
   input  logic   i_mem_ready,
   output ctrl_t  o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         ST_FETCH: begin
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.alu_src_b = SRCB_FOUR;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_ctrl.pc_source = PCSRC_ALU;
            o_ctrl.ir_write  = i_mem_ready;
            o_ctrl.pc_en     = i_mem_ready;
         end
         ST_DECODE: begin
            o_ctrl.alu_src_b = SRCB_IMM_SH2;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         ST_MEM_ADDR, ST_ADDI_EXEC: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         ST_MEM_READ: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
         end
         ST_MEM_WRITE: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.i_or_d    = 1'b1;
         end
         ST_EXECUTE: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_REG;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         ST_R_WB: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dst   = 1'b1;
         end
         ST_BRANCH: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_REG;
            o_ctrl.alu_op    = ALUOP_SUB;
            o_ctrl.pc_source = PCSRC_ALUOUT;
            o_ctrl.pc_en     = i_zero;
         end
         ST_JUMP: begin
            o_ctrl.pc_source = PCSRC_JUMP;
            o_ctrl.pc_en     = 1'b1;
         end
         ST_ADDI_WB: begin
            o_ctrl.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multicycle MIPS-subset datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter bit ENABLE_ADDI = 1'b1
)(
   input  logic               clk,
   input  logic               reset,
   multicycle_control_if.master bus
);

   state_t r_state;
   state_t w_next_state;
   state_t w_decoded;
   ctrl_t  w_ctrl;
   ctrl_t  w_out;
   logic   w_illegal;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_FETCH;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = ST_FETCH;
      w_illegal    = 1'b0;
      w_decoded    = decode_opcode(bus.opcode, ENABLE_ADDI);
      case (r_state)
         ST_FETCH:     w_next_state = bus.mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            w_next_state = w_decoded;
            w_illegal    = (w_decoded == ST_FETCH);
         end
         ST_MEM_ADDR: begin
            if (bus.opcode == OP_LW)      w_next_state = ST_MEM_READ;
            else if (bus.opcode == OP_SW) w_next_state = ST_MEM_WRITE;
            else                          w_next_state = ST_FETCH;
         end
         ST_MEM_READ:  w_next_state = bus.mem_ready ? ST_MEM_WB : ST_MEM_READ;
         ST_MEM_WRITE: w_next_state = bus.mem_ready ? ST_FETCH : ST_MEM_WRITE;
         ST_EXECUTE:   w_next_state = ST_R_WB;
         ST_ADDI_EXEC: w_next_state = ST_ADDI_WB;
         // Terminal states and unused encodings all return to FETCH.
         default:      w_next_state = ST_FETCH;
      endcase
   end

   multicycle_control_decode u_decode (
      .i_state     (r_state),
      .i_zero      (bus.zero),
      .i_mem_ready (bus.mem_ready),
      .o_ctrl      (w_ctrl)
   );

   // Reset silences every control line immediately, before the state register clears.
   assign w_out          = reset ? '0 : w_ctrl;
   assign bus.pc_en      = w_out.pc_en;
   assign bus.i_or_d     = w_out.i_or_d;
   assign bus.mem_read   = w_out.mem_read;
   assign bus.mem_write  = w_out.mem_write;
   assign bus.ir_write   = w_out.ir_write;
   assign bus.mem_to_reg = w_out.mem_to_reg;
   assign bus.reg_dst    = w_out.reg_dst;
   assign bus.reg_write  = w_out.reg_write;
   assign bus.alu_src_a  = w_out.alu_src_a;
   assign bus.alu_src_b  = w_out.alu_src_b;
   assign bus.alu_op     = w_out.alu_op;
   assign bus.pc_source  = w_out.pc_source;
   assign bus.illegal    = w_illegal & ~reset;
   assign bus.state      = reset ? 4'd0 : r_state;

endmodule
`default_nettype wire
